age_issue_queue: RTL and testbench
==================================

AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of queue entries, at least 2.
REQ-002 SHALL have parameter DISPATCH_NUM, default 4: number of dispatch slots per cycle, at most DEPTH.
REQ-003 SHALL have parameter ISSUE_NUM, default 4: number of issue ports.
REQ-004 SHALL have parameter WAKE_NUM, default 4: number of wakeup broadcast channels.
REQ-005 SHALL have parameter PRF_WIDTH, default 6: physical register tag width.
REQ-006 SHALL have parameter PAYLOAD_WIDTH, default 75: opaque per-instruction data (opcode, func3, func7, imme).
REQ-007 SHALL use one clock and a synchronous, active-high reset, with these ports:
  clk  in  1  clock; all state updates on its rising edge
  rst  in  1  synchronous, active-high reset
  disp_valid  in  DISPATCH_NUM  per-slot dispatch request
  disp_ready  out  1  queue can accept a full dispatch group this cycle
  disp_payload  in  DISPATCH_NUM*PAYLOAD_WIDTH  per-slot payload
  disp_prs1 / disp_prs2 / disp_prd  in  DISPATCH_NUM*PRF_WIDTH each  source and destination tags
  disp_prs1_v / disp_prs2_v / disp_prd_v  in  DISPATCH_NUM each  operand-present flags
  disp_prs1_rdy / disp_prs2_rdy  in  DISPATCH_NUM each  operand already available at dispatch
  wake_valid  in  WAKE_NUM  broadcast valid
  wake_tag  in  WAKE_NUM*PRF_WIDTH  broadcast destination tags
  iss_ready  in  ISSUE_NUM  execution port can accept this cycle
  iss_valid  out  ISSUE_NUM  port carries a selected instruction
  iss_payload / iss_prs1 / iss_prs2 / iss_prd  out  ISSUE_NUM*(matching width)  selected entry fields
  iss_prd_v  out  ISSUE_NUM  selected entry destination-present flag
  flush  in  1  discard all entries
  free_cnt  out  $clog2(DEPTH+1)  number of free entries

Function
REQ-008 Each entry SHALL hold valid, payload, prs1/prs2/prd, their _v flags, rdy1, rdy2, and an age-matrix row of DEPTH bits.
REQ-009 disp_ready SHALL equal (free_cnt >= DISPATCH_NUM) and !rst; it is computed from registered state only and ignores entries freed in the same cycle.
REQ-010 Dispatch fires when disp_ready is 1 and any disp_valid bit is 1; the k-th set disp_valid slot, in ascending slot order, SHALL be written to the k-th lowest-index free entry at the next edge.
REQ-011 Slots with disp_valid=0 SHALL write nothing; disp_valid asserted while disp_ready is 0 SHALL be dropped with no state change.
REQ-012 On write: rdy1 = !prs1_v | disp_prs1_rdy | (a same-cycle wake_valid tag equals prs1); rdy2 is formed the same way from prs2.
REQ-013 Each cycle, any valid entry whose prsN_v=1 and prsN matches a valid wake_tag SHALL set rdyN=1 at the next edge; rdyN SHALL never clear while the entry is valid.
REQ-014 An entry is eligible when valid & rdy1 & rdy2, using registered values; a wakeup therefore makes the entry eligible one cycle later.
REQ-015 Age matrix: the row of a newly written entry SHALL mark every currently valid entry and every lower-numbered slot written in the same group as older.
REQ-016 Selection SHALL be combinational from registered state: eligible entries are ordered oldest-first and assigned to ports with iss_ready=1 in ascending port index.
REQ-017 Ports with iss_ready=0, or with no remaining eligible entry, SHALL drive iss_valid=0; their data outputs are don't-care.
REQ-018 Each entry driven with iss_valid=1 SHALL have valid cleared at the next edge; no entry SHALL be granted to two ports.
REQ-019 free_cnt SHALL update at each edge: free_cnt - dispatched + issued; it never exceeds DEPTH and never underflows.
REQ-020 When dispatch and issue occur in the same cycle, both SHALL take effect, and a freed entry becomes reusable no earlier than the following cycle.
REQ-021 flush=1 SHALL clear all valid bits at the next edge and force iss_valid=0 and disp_ready=0 in that cycle; flush has priority over dispatch and issue.
REQ-022 The full condition (free_cnt < DISPATCH_NUM) SHALL hold off dispatch only; issue and wakeup continue unaffected.

Reset
REQ-023 rst=1 SHALL clear all valid, rdy and age bits at the edge, set free_cnt=DEPTH, and force iss_valid=0 and disp_ready=0 while asserted.
REQ-024 rst asserted during activity SHALL drop all in-flight dispatch and wakeup; the first cycle after deassertion shows disp_ready=1 and free_cnt=DEPTH.

Verification
REQ-025 Reset, then dispatch 4 ready instructions (prs1_v=prs2_v=0) -> entries 0-3 written; next cycle iss_valid=4'b1111 with port0=slot0 ... port3=slot3; free_cnt goes 16->12->16.
REQ-026 Dispatch A (prs1=6'd10, rdy=0), then wake_tag=6'd10 one cycle later -> A eligible one cycle after the wake, never earlier.
REQ-027 Same-cycle bypass: dispatch B (prs2=6'd7, rdy=0) while wake_tag=6'd7 -> B issues the cycle after its dispatch.
REQ-028 Fill 16 entries with prs1 never ready -> disp_ready=0 once free_cnt=0 (and already once free_cnt<4); further disp_valid is ignored and free_cnt stays 0.
REQ-029 Five ready entries of ages 0-4, iss_ready=4'b1010 -> port1 gets the oldest and port3 the second oldest; ports 0 and 2 show iss_valid=0.
REQ-030 flush asserted in the same cycle as dispatch of 4 and issue of 2 -> all entries cleared, free_cnt=16, iss_valid=0 in that cycle, and no dispatched entry survives.

Source files
------------

// File: rtl/age_issue_queue_if.sv
// Dispatch, wakeup, issue and status signals of the age-ordered issue queue.
interface age_issue_queue_if #(
  parameter int DEPTH         = 16,
  parameter int DISPATCH_NUM  = 4,
  parameter int ISSUE_NUM     = 4,
  parameter int WAKE_NUM      = 4,
  parameter int PRF_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 75
);
  logic [DISPATCH_NUM-1:0]               disp_valid;
  logic                                  disp_ready;
  logic [DISPATCH_NUM*PAYLOAD_WIDTH-1:0] disp_payload;
  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prs1;
  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prs2;
  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prd;
  logic [DISPATCH_NUM-1:0]               disp_prs1_v;
  logic [DISPATCH_NUM-1:0]               disp_prs2_v;
  logic [DISPATCH_NUM-1:0]               disp_prd_v;
  logic [DISPATCH_NUM-1:0]               disp_prs1_rdy;
  logic [DISPATCH_NUM-1:0]               disp_prs2_rdy;
  logic [WAKE_NUM-1:0]                   wake_valid;
  logic [WAKE_NUM*PRF_WIDTH-1:0]         wake_tag;
  logic [ISSUE_NUM-1:0]                  iss_ready;
  logic [ISSUE_NUM-1:0]                  iss_valid;
  logic [ISSUE_NUM*PAYLOAD_WIDTH-1:0]    iss_payload;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prs1;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prs2;
  logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prd;
  logic [ISSUE_NUM-1:0]                  iss_prd_v;
  logic                                  flush;
  logic [$clog2(DEPTH+1)-1:0]            free_cnt;

  modport master (
    output disp_valid, disp_payload, disp_prs1, disp_prs2, disp_prd,
           disp_prs1_v, disp_prs2_v, disp_prd_v, disp_prs1_rdy, disp_prs2_rdy,
           wake_valid, wake_tag, iss_ready, flush,
    input  disp_ready, iss_valid, iss_payload, iss_prs1, iss_prs2, iss_prd,
           iss_prd_v, free_cnt
  );

  modport slave (
    input  disp_valid, disp_payload, disp_prs1, disp_prs2, disp_prd,
           disp_prs1_v, disp_prs2_v, disp_prd_v, disp_prs1_rdy, disp_prs2_rdy,
           wake_valid, wake_tag, iss_ready, flush,
    output disp_ready, iss_valid, iss_payload, iss_prs1, iss_prs2, iss_prd,
           iss_prd_v, free_cnt
  );
endinterface

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: compacting dispatch into free entries, tag wakeup,
// oldest-first multi-port select tracked with an age matrix.
module age_issue_queue #(
  parameter int DEPTH         = 16,
  parameter int DISPATCH_NUM  = 4,
  parameter int ISSUE_NUM     = 4,
  parameter int WAKE_NUM      = 4,
  parameter int PRF_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 75
) (
  input  logic               clk,
  input  logic               rst,
  age_issue_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = (DISPATCH_NUM > 1) ? $clog2(DISPATCH_NUM) : 1;
  localparam int RW = $clog2(DEPTH + DISPATCH_NUM + ISSUE_NUM + 1);

  logic [DEPTH-1:0]         r_valid, r_rdy1, r_rdy2;
  logic [DEPTH-1:0]         r_prs1_v, r_prs2_v, r_prd_v;
  logic [PAYLOAD_WIDTH-1:0] r_payload [DEPTH];
  logic [PRF_WIDTH-1:0]     r_prs1 [DEPTH];
  logic [PRF_WIDTH-1:0]     r_prs2 [DEPTH];
  logic [PRF_WIDTH-1:0]     r_prd  [DEPTH];
  logic [DEPTH-1:0]         r_age  [DEPTH];
  logic [CW-1:0]            r_free_cnt;

  logic                     w_block, w_disp_ready, w_fire;
  logic [DEPTH-1:0]         w_elig, w_grant, w_wr_en, w_hit1, w_hit2;
  logic [DISPATCH_NUM-1:0]  w_bp1, w_bp2;
  logic [RW-1:0]            w_rank [DEPTH];
  logic [RW-1:0]            w_free_rank [DEPTH];
  logic [RW-1:0]            w_slot_rank [DISPATCH_NUM];
  logic [RW-1:0]            w_disp_cnt, w_free_acc, w_port_cnt, w_iss_cnt;
  logic [SW-1:0]            w_wr_slot [DEPTH];
  logic [DEPTH-1:0]         w_new_row [DEPTH];
  logic [ISSUE_NUM-1:0]     w_iss_vld;
  logic [IW-1:0]            w_iss_idx [ISSUE_NUM];

  assign w_block      = rst | bus.flush;
  assign w_disp_ready = !w_block && (r_free_cnt >= CW'(DISPATCH_NUM));
  assign w_fire       = w_disp_ready && (|bus.disp_valid);
  assign bus.disp_ready = w_disp_ready;
  assign bus.free_cnt   = r_free_cnt;

  // Tag match for stored entries and for the incoming dispatch group (bypass).
  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    w_bp1  = '0;
    w_bp2  = '0;
    for (int unsigned w = 0; w < WAKE_NUM; w++) begin
      if (bus.wake_valid[w]) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (r_prs1[e] == bus.wake_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_hit1[e] = 1'b1;
          if (r_prs2[e] == bus.wake_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_hit2[e] = 1'b1;
        end
        for (int unsigned s = 0; s < DISPATCH_NUM; s++) begin
          if (bus.disp_prs1[s*PRF_WIDTH +: PRF_WIDTH] == bus.wake_tag[w*PRF_WIDTH +: PRF_WIDTH])
            w_bp1[s] = 1'b1;
          if (bus.disp_prs2[s*PRF_WIDTH +: PRF_WIDTH] == bus.wake_tag[w*PRF_WIDTH +: PRF_WIDTH])
            w_bp2[s] = 1'b1;
        end
      end
    end
  end

  // k-th valid slot goes to the k-th lowest free entry: match slot rank to free rank.
  always_comb begin
    w_disp_cnt = '0;
    for (int unsigned s = 0; s < DISPATCH_NUM; s++) begin
      w_slot_rank[s] = w_disp_cnt;
      if (bus.disp_valid[s]) w_disp_cnt = w_disp_cnt + RW'(1);
    end
    w_free_acc = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      w_free_rank[e] = w_free_acc;
      if (!r_valid[e]) w_free_acc = w_free_acc + RW'(1);
    end
    w_wr_en = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      w_wr_slot[e] = '0;
      if (w_fire && !r_valid[e]) begin
        for (int unsigned s = 0; s < DISPATCH_NUM; s++) begin
          if (bus.disp_valid[s] && (w_slot_rank[s] == w_free_rank[e])) begin
            w_wr_en[e]   = 1'b1;
            w_wr_slot[e] = SW'(s);
          end
        end
      end
    end
    for (int unsigned e = 0; e < DEPTH; e++) begin
      w_new_row[e] = r_valid;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (w_wr_en[j] && (w_wr_slot[j] < w_wr_slot[e])) w_new_row[e][j] = 1'b1;
      end
    end
  end

  // Rank = number of older eligible entries; the n-th ready port takes rank n.
  always_comb begin
    w_elig = r_valid & r_rdy1 & r_rdy2;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      w_rank[e] = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (r_age[e][j] && w_elig[j]) w_rank[e] = w_rank[e] + RW'(1);
      end
    end
    w_grant    = '0;
    w_port_cnt = '0;
    w_iss_cnt  = '0;
    for (int unsigned p = 0; p < ISSUE_NUM; p++) begin
      w_iss_vld[p] = 1'b0;
      w_iss_idx[p] = '0;
      if (bus.iss_ready[p] && !w_block) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (w_elig[e] && (w_rank[e] == w_port_cnt)) begin
            w_iss_vld[p] = 1'b1;
            w_iss_idx[p] = IW'(e);
            w_grant[e]   = 1'b1;
          end
        end
        if (w_iss_vld[p]) w_iss_cnt = w_iss_cnt + RW'(1);
        w_port_cnt = w_port_cnt + RW'(1);
      end
    end
  end

  always_comb begin
    bus.iss_valid   = w_iss_vld;
    bus.iss_payload = '0;
    bus.iss_prs1    = '0;
    bus.iss_prs2    = '0;
    bus.iss_prd     = '0;
    bus.iss_prd_v   = '0;
    for (int unsigned p = 0; p < ISSUE_NUM; p++) begin
      bus.iss_payload[p*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = r_payload[w_iss_idx[p]];
      bus.iss_prs1[p*PRF_WIDTH +: PRF_WIDTH]            = r_prs1[w_iss_idx[p]];
      bus.iss_prs2[p*PRF_WIDTH +: PRF_WIDTH]            = r_prs2[w_iss_idx[p]];
      bus.iss_prd[p*PRF_WIDTH +: PRF_WIDTH]             = r_prd[w_iss_idx[p]];
      bus.iss_prd_v[p]                                  = r_prd_v[w_iss_idx[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      r_free_cnt <= CW'(DEPTH);
      for (int unsigned e = 0; e < DEPTH; e++) r_age[e] <= '0;
    end else if (bus.flush) begin
      r_valid    <= '0;
      r_free_cnt <= CW'(DEPTH);
    end else begin
      r_free_cnt <= r_free_cnt - (w_fire ? CW'(w_disp_cnt) : CW'(0)) + CW'(w_iss_cnt);
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (w_wr_en[e]) begin
          r_valid[e]   <= 1'b1;
          r_payload[e] <= bus.disp_payload[w_wr_slot[e]*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
          r_prs1[e]    <= bus.disp_prs1[w_wr_slot[e]*PRF_WIDTH +: PRF_WIDTH];
          r_prs2[e]    <= bus.disp_prs2[w_wr_slot[e]*PRF_WIDTH +: PRF_WIDTH];
          r_prd[e]     <= bus.disp_prd[w_wr_slot[e]*PRF_WIDTH +: PRF_WIDTH];
          r_prs1_v[e]  <= bus.disp_prs1_v[w_wr_slot[e]];
          r_prs2_v[e]  <= bus.disp_prs2_v[w_wr_slot[e]];
          r_prd_v[e]   <= bus.disp_prd_v[w_wr_slot[e]];
          r_rdy1[e]    <= !bus.disp_prs1_v[w_wr_slot[e]] || bus.disp_prs1_rdy[w_wr_slot[e]]
                          || w_bp1[w_wr_slot[e]];
          r_rdy2[e]    <= !bus.disp_prs2_v[w_wr_slot[e]] || bus.disp_prs2_rdy[w_wr_slot[e]]
                          || w_bp2[w_wr_slot[e]];
          r_age[e]     <= w_new_row[e];
        end else begin
          if (w_grant[e]) r_valid[e] <= 1'b0;
          if (r_prs1_v[e] && w_hit1[e]) r_rdy1[e] <= 1'b1;
          if (r_prs2_v[e] && w_hit2[e]) r_rdy2[e] <= 1'b1;
          // A reused entry is younger than everything: drop its stale column bits.
          for (int unsigned j = 0; j < DEPTH; j++) begin
            if (w_wr_en[j]) r_age[e][j] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_age_issue_queue.sv
// Bench for age_issue_queue: directed scenarios plus random traffic checked
// against a timestamp-ordered reference model of the queue.
module tb_age_issue_queue;
  localparam int D    = 16;
  localparam int DN   = 4;
  localparam int IN   = 4;
  localparam int WN   = 4;
  localparam int PRW  = 6;
  localparam int PAYW = 75;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  age_issue_queue_if #(.DEPTH(D), .DISPATCH_NUM(DN), .ISSUE_NUM(IN), .WAKE_NUM(WN),
                       .PRF_WIDTH(PRW), .PAYLOAD_WIDTH(PAYW)) bus ();

  age_issue_queue #(.DEPTH(D), .DISPATCH_NUM(DN), .ISSUE_NUM(IN), .WAKE_NUM(WN),
                    .PRF_WIDTH(PRW), .PAYLOAD_WIDTH(PAYW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each entry stamped with a dispatch sequence number.
  bit                m_known = 1'b0;
  bit                m_v  [D];
  bit                m_p1v[D], m_p2v[D], m_pdv[D], m_r1[D], m_r2[D];
  int unsigned       m_seq[D];
  logic [PAYW-1:0]   m_pay[D];
  logic [PRW-1:0]    m_p1[D], m_p2[D], m_pd[D];
  int unsigned       m_ctr = 0;
  int                nfree;
  bit                exp_dr;
  int                g[IN];
  bit                used[D], old_v[D];

  initial for (int e = 0; e < D; e++) m_v[e] = 1'b0;

  function automatic bit woke(input logic [PRW-1:0] t);
    bit hit = 1'b0;
    for (int w = 0; w < WN; w++)
      if (bus.wake_valid[w] && bus.wake_tag[w*PRW +: PRW] == t) hit = 1'b1;
    return hit;
  endfunction

  always @(negedge clk) begin
    nfree = 0;
    for (int e = 0; e < D; e++) if (!m_v[e]) nfree++;
    exp_dr = !rst && !bus.flush && (nfree >= DN);
    for (int e = 0; e < D; e++) used[e] = 1'b0;
    for (int p = 0; p < IN; p++) begin
      g[p] = -1;
      if (bus.iss_ready[p] && !rst && !bus.flush)
        for (int e = 0; e < D; e++)
          if (m_v[e] && m_r1[e] && m_r2[e] && !used[e] &&
              (g[p] < 0 || m_seq[e] < m_seq[g[p]])) g[p] = e;
      if (g[p] >= 0) used[g[p]] = 1'b1;
    end
    if (m_known) begin
      chk("disp_ready", 128'(bus.disp_ready), 128'(exp_dr));
      chk("free_cnt", 128'(bus.free_cnt), 128'(nfree));
      for (int p = 0; p < IN; p++) begin
        chk($sformatf("iss_valid[%0d]", p), 128'(bus.iss_valid[p]), 128'(g[p] >= 0));
        if (g[p] >= 0) begin
          chk($sformatf("iss_payload[%0d]", p), 128'(bus.iss_payload[p*PAYW +: PAYW]), 128'(m_pay[g[p]]));
          chk($sformatf("iss_prs1[%0d]", p), 128'(bus.iss_prs1[p*PRW +: PRW]), 128'(m_p1[g[p]]));
          chk($sformatf("iss_prs2[%0d]", p), 128'(bus.iss_prs2[p*PRW +: PRW]), 128'(m_p2[g[p]]));
          chk($sformatf("iss_prd[%0d]", p), 128'(bus.iss_prd[p*PRW +: PRW]), 128'(m_pd[g[p]]));
          chk($sformatf("iss_prd_v[%0d]", p), 128'(bus.iss_prd_v[p]), 128'(m_pdv[g[p]]));
        end
      end
    end
    if (rst) begin
      for (int e = 0; e < D; e++) m_v[e] = 1'b0;
      m_known = 1'b1;
    end else if (bus.flush) begin
      for (int e = 0; e < D; e++) m_v[e] = 1'b0;
    end else begin
      for (int e = 0; e < D; e++) begin
        old_v[e] = m_v[e];
        if (m_p1v[e] && woke(m_p1[e])) m_r1[e] = 1'b1;
        if (m_p2v[e] && woke(m_p2[e])) m_r2[e] = 1'b1;
      end
      for (int p = 0; p < IN; p++) if (g[p] >= 0) m_v[g[p]] = 1'b0;
      if (exp_dr) begin
        for (int s = 0; s < DN; s++) begin
          if (bus.disp_valid[s]) begin
            int e = 0;
            while (old_v[e]) e++;
            old_v[e]  = 1'b1;
            m_v[e]    = 1'b1;
            m_seq[e]  = m_ctr++;
            m_pay[e]  = bus.disp_payload[s*PAYW +: PAYW];
            m_p1[e]   = bus.disp_prs1[s*PRW +: PRW];
            m_p2[e]   = bus.disp_prs2[s*PRW +: PRW];
            m_pd[e]   = bus.disp_prd[s*PRW +: PRW];
            m_p1v[e]  = bus.disp_prs1_v[s];
            m_p2v[e]  = bus.disp_prs2_v[s];
            m_pdv[e]  = bus.disp_prd_v[s];
            m_r1[e]   = !m_p1v[e] || bus.disp_prs1_rdy[s] || woke(m_p1[e]);
            m_r2[e]   = !m_p2v[e] || bus.disp_prs2_rdy[s] || woke(m_p2[e]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.disp_valid = '0;
    bus.wake_valid = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic put(input int s, input logic [PAYW-1:0] pay,
                     input logic [PRW-1:0] p1, input bit p1v, input bit p1r,
                     input logic [PRW-1:0] p2, input bit p2v, input bit p2r);
    bus.disp_valid[s]             = 1'b1;
    bus.disp_payload[s*PAYW +: PAYW] = pay;
    bus.disp_prs1[s*PRW +: PRW]   = p1;
    bus.disp_prs2[s*PRW +: PRW]   = p2;
    bus.disp_prd[s*PRW +: PRW]    = PRW'(s + 32);
    bus.disp_prs1_v[s]            = p1v;
    bus.disp_prs2_v[s]            = p2v;
    bus.disp_prd_v[s]             = 1'b1;
    bus.disp_prs1_rdy[s]          = p1r;
    bus.disp_prs2_rdy[s]          = p2r;
  endtask

  initial begin
    rst = 1'b1;
    bus.disp_payload = '0; bus.disp_prs1 = '0; bus.disp_prs2 = '0; bus.disp_prd = '0;
    bus.disp_prs1_v = '0; bus.disp_prs2_v = '0; bus.disp_prd_v = '0;
    bus.disp_prs1_rdy = '0; bus.disp_prs2_rdy = '0; bus.wake_tag = '0;
    bus.iss_ready = '0;
    clr();
    repeat (2) cyc();
    #1;
    chk("rst disp_ready", 128'(bus.disp_ready), 128'(0));
    chk("rst iss_valid", 128'(bus.iss_valid), 128'(0));

    // Four ready instructions issue together, oldest on port 0.
    cyc(); rst = 1'b0; #1;
    chk("post-rst free_cnt", 128'(bus.free_cnt), 128'(16));
    chk("post-rst disp_ready", 128'(bus.disp_ready), 128'(1));
    for (int s = 0; s < 4; s++) put(s, PAYW'(100 + s), '0, 0, 0, '0, 0, 0);
    cyc(); clr(); bus.iss_ready = 4'b1111; #1;
    chk("grp free_cnt 12", 128'(bus.free_cnt), 128'(12));
    chk("grp iss_valid", 128'(bus.iss_valid), 128'(4'b1111));
    for (int p = 0; p < 4; p++)
      chk($sformatf("grp port%0d", p), 128'(bus.iss_payload[p*PAYW +: PAYW]), 128'(100 + p));
    cyc(); #1;
    chk("grp free_cnt 16", 128'(bus.free_cnt), 128'(16));

    // Wakeup makes an entry eligible one cycle after the broadcast.
    put(0, PAYW'(200), 6'd10, 1, 0, '0, 0, 0);
    cyc(); clr(); #1;
    chk("A before wake", 128'(bus.iss_valid), 128'(0));
    bus.wake_valid = 4'b0001; bus.wake_tag[0 +: PRW] = 6'd10; #1;
    chk("A wake cycle", 128'(bus.iss_valid), 128'(0));
    cyc(); clr(); #1;
    chk("A after wake", 128'(bus.iss_valid), 128'(4'b0001));
    chk("A payload", 128'(bus.iss_payload[0 +: PAYW]), 128'(200));
    cyc();

    // Same-cycle wakeup bypass at dispatch.
    put(0, PAYW'(300), '0, 0, 0, 6'd7, 1, 0);
    bus.wake_valid = 4'b0100; bus.wake_tag[2*PRW +: PRW] = 6'd7;
    cyc(); clr(); #1;
    chk("B bypass", 128'(bus.iss_valid), 128'(4'b0001));
    chk("B payload", 128'(bus.iss_payload[0 +: PAYW]), 128'(300));
    cyc();

    // Oldest-first on sparse ready ports.
    bus.iss_ready = '0;
    for (int s = 0; s < 4; s++) put(s, PAYW'(400 + s), '0, 0, 0, '0, 0, 0);
    cyc(); clr();
    put(0, PAYW'(404), '0, 0, 0, '0, 0, 0);
    cyc(); clr(); bus.iss_ready = 4'b1010; #1;
    chk("sparse iss_valid", 128'(bus.iss_valid), 128'(4'b1010));
    chk("sparse port1", 128'(bus.iss_payload[1*PAYW +: PAYW]), 128'(400));
    chk("sparse port3", 128'(bus.iss_payload[3*PAYW +: PAYW]), 128'(401));
    cyc(); bus.iss_ready = 4'b1111; #1;
    chk("rest iss_valid", 128'(bus.iss_valid), 128'(4'b0111));
    chk("rest port0", 128'(bus.iss_payload[0 +: PAYW]), 128'(402));
    cyc();

    // Flush wins over simultaneous dispatch and issue.
    bus.iss_ready = '0;
    for (int s = 0; s < 4; s++) put(s, PAYW'(500 + s), '0, 0, 0, '0, 0, 0);
    cyc(); clr();
    for (int s = 0; s < 4; s++) put(s, PAYW'(504 + s), '0, 0, 0, '0, 0, 0);
    bus.iss_ready = 4'b0011; bus.flush = 1'b1; #1;
    chk("flush iss_valid", 128'(bus.iss_valid), 128'(0));
    chk("flush disp_ready", 128'(bus.disp_ready), 128'(0));
    cyc(); clr(); bus.iss_ready = 4'b1111; #1;
    chk("flush free_cnt", 128'(bus.free_cnt), 128'(16));
    chk("flush no survivor", 128'(bus.iss_valid), 128'(0));

    // Fill with never-ready entries; full holds off dispatch.
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) put(s, PAYW'(600 + s), 6'd63, 1, 0, '0, 0, 0);
      cyc(); clr(); #1;
      chk($sformatf("fill free_cnt %0d", k), 128'(bus.free_cnt), 128'(12 - 4 * k));
    end
    chk("full disp_ready", 128'(bus.disp_ready), 128'(0));
    for (int s = 0; s < 4; s++) put(s, PAYW'(700), '0, 0, 0, '0, 0, 0);
    cyc(); cyc(); clr(); #1;
    chk("full stays 0", 128'(bus.free_cnt), 128'(0));
    chk("full no issue", 128'(bus.iss_valid), 128'(0));
    bus.flush = 1'b1;
    cyc(); clr();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < (k == 3 ? 3 : 4); s++) put(s, PAYW'(800 + s), 6'd63, 1, 0, '0, 0, 0);
      cyc(); clr();
    end
    #1;
    chk("near-full free_cnt", 128'(bus.free_cnt), 128'(1));
    chk("near-full disp_ready", 128'(bus.disp_ready), 128'(0));
    bus.flush = 1'b1;
    cyc(); clr();

    // Random traffic including rare flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.flush      = ($urandom_range(0, 63) == 0);
      bus.iss_ready  = IN'($urandom);
      bus.disp_valid = ($urandom_range(0, 2) == 0) ? '0 : DN'($urandom);
      for (int s = 0; s < DN; s++) begin
        bus.disp_payload[s*PAYW +: PAYW] = PAYW'({$urandom, $urandom, $urandom});
        bus.disp_prs1[s*PRW +: PRW] = PRW'($urandom_range(0, 15));
        bus.disp_prs2[s*PRW +: PRW] = PRW'($urandom_range(0, 15));
        bus.disp_prd[s*PRW +: PRW]  = PRW'($urandom);
        bus.disp_prs1_v[s]   = $urandom_range(0, 1) == 1;
        bus.disp_prs2_v[s]   = $urandom_range(0, 1) == 1;
        bus.disp_prd_v[s]    = $urandom_range(0, 1) == 1;
        bus.disp_prs1_rdy[s] = $urandom_range(0, 3) == 0;
        bus.disp_prs2_rdy[s] = $urandom_range(0, 3) == 0;
      end
      bus.wake_valid = WN'($urandom) & WN'($urandom);
      for (int w = 0; w < WN; w++) bus.wake_tag[w*PRW +: PRW] = PRW'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b0;
    clr();
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
